// File: rtl/ym_bus_pkg.sv
// Shared types and decode constants for the YM2149 TurboSound bus sequencer.
package ym_bus_pkg;

  typedef enum logic [1:0] {StIdle, StQual, StDrive, StHold} state_e;

  typedef enum logic [2:0] {AccNone, AccLatch, AccWrite, AccRead, AccSelect} acc_e;

  // Port matches on {a15, a14, a1, a0}
  localparam logic [3:0] PortFffd = 4'b1101;
  localparam logic [3:0] PortBffd = 4'b1001;

  localparam logic [7:0] SelChip0 = 8'hFF;
  localparam logic [7:0] SelChip1 = 8'hFE;

  // {bc1, bdir} for a driven access class
  function automatic logic [1:0] drive_bits(acc_e cls);
    logic [1:0] bits;
    bits = 2'b00;
    case (cls)
      AccLatch: bits = 2'b11;
      AccWrite: bits = 2'b01;
      AccRead:  bits = 2'b10;
      default:  bits = 2'b00;
    endcase
    return bits;
  endfunction

endpackage

// File: rtl/ym_bus_sequencer_if.sv
// Z80-side bus and PSG pin bundle for the YM bus sequencer.
interface ym_bus_sequencer_if;
  logic       iorq;
  logic       m1;
  logic       wr;
  logic       rd;
  logic       dos;
  logic       a15;
  logic       a14;
  logic       a1;
  logic       a0;
  logic [7:0] d;
  logic       turbo;
  logic       bc1;
  logic       bdir;
  logic       ym_0;
  logic       ym_1;
  logic       ym_clock;

  modport master (
    output iorq, m1, wr, rd, dos, a15, a14, a1, a0, d, turbo,
    input  bc1, bdir, ym_0, ym_1, ym_clock
  );

  modport slave (
    input  iorq, m1, wr, rd, dos, a15, a14, a1, a0, d, turbo,
    output bc1, bdir, ym_0, ym_1, ym_clock
  );
endinterface

// File: rtl/ym_clk_div.sv
// PSG clock divider; the turbo ratio only switches at the end of a high phase.
module ym_clk_div #(
  parameter int unsigned DIV_NORMAL = 2,
  parameter int unsigned DIV_TURBO  = 4
) (
  input  logic cpu_clock,
  input  logic reset,
  input  logic turbo,
  output logic ym_clock
);

  localparam int unsigned CntW = 8;
  localparam logic [CntW-1:0] HalfNormM1 = CntW'(DIV_NORMAL / 2 - 1);
  localparam logic [CntW-1:0] HalfTurboM1 = CntW'(DIV_TURBO / 2 - 1);

  logic [CntW-1:0] cnt_q;
  logic            turbo_q;
  logic            ym_q;
  logic [CntW-1:0] half_m1;

  assign half_m1  = turbo_q ? HalfTurboM1 : HalfNormM1;
  assign ym_clock = ym_q;

  always_ff @(posedge cpu_clock or posedge reset) begin
    if (reset) begin
      cnt_q   <= '0;
      turbo_q <= 1'b0;
      ym_q    <= 1'b0;
    end else if (cnt_q == half_m1) begin
      cnt_q <= '0;
      ym_q  <= ~ym_q;
      // Switching only as ym_clock falls keeps every phase whole
      if (ym_q) begin
        turbo_q <= turbo;
      end
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/ym_bus_sequencer.sv
// Qualifies Z80 I/O cycles on #FFFD/#BFFD and drives BC1/BDIR plus TurboSound chip select.
module ym_bus_sequencer
  import ym_bus_pkg::*;
#(
  parameter int unsigned QUAL_CYCLES = 1,
  parameter int unsigned DIV_NORMAL  = 2,
  parameter int unsigned DIV_TURBO   = 4
) (
  input logic           cpu_clock,
  input logic           reset,
  ym_bus_sequencer_if.slave bus
);

  state_e     state_q;
  acc_e       cap_q;
  acc_e       cls;
  logic [1:0] qcnt_q;
  logic       bc1_q;
  logic       bdir_q;
  logic       sel_q;
  logic       armed_q;
  logic       illegal;
  logic       gate;
  logic [3:0] port;

  assign port = {bus.a15, bus.a14, bus.a1, bus.a0};
  assign gate = bus.dos & bus.m1 & ~bus.iorq;
  assign illegal = gate & ~bus.wr & ~bus.rd & ((port == PortFffd) | (port == PortBffd));

  always_comb begin
    cls = AccNone;
    if (gate && (bus.wr ^ bus.rd)) begin
      if (port == PortFffd && !bus.wr) begin
        cls = (bus.d == SelChip0 || bus.d == SelChip1) ? AccSelect : AccLatch;
      end else if (port == PortFffd && !bus.rd) begin
        cls = AccRead;
      end else if (port == PortBffd && !bus.wr) begin
        cls = AccWrite;
      end
    end
  end

  always_ff @(posedge cpu_clock or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      cap_q   <= AccNone;
      qcnt_q  <= 2'd0;
      bc1_q   <= 1'b0;
      bdir_q  <= 1'b0;
      sel_q   <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      // A cycle already in flight at reset release is not picked up mid-way
      if (bus.iorq) begin
        armed_q <= 1'b1;
      end
      case (state_q)
        StIdle: begin
          if (armed_q) begin
            if (illegal) begin
              state_q <= StHold;
            end else if (cls != AccNone) begin
              cap_q   <= cls;
              qcnt_q  <= 2'd0;
              state_q <= StQual;
            end
          end
        end
        StQual: begin
          if (bus.iorq) begin
            state_q <= StIdle;
          end else if (cls != cap_q) begin
            state_q <= StHold;
          end else if (qcnt_q == 2'(QUAL_CYCLES - 1)) begin
            state_q          <= StDrive;
            {bc1_q, bdir_q}  <= drive_bits(cap_q);
            if (cap_q == AccSelect) begin
              sel_q <= (bus.d == SelChip1);
            end
          end else begin
            qcnt_q <= qcnt_q + 2'd1;
          end
        end
        StDrive: begin
          if (bus.iorq) begin
            state_q <= StIdle;
            bc1_q   <= 1'b0;
            bdir_q  <= 1'b0;
          end
        end
        StHold: begin
          if (bus.iorq) begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.bc1  = bc1_q & ~bus.iorq;
  assign bus.bdir = bdir_q & ~bus.iorq;
  assign bus.ym_0 = ~sel_q;
  assign bus.ym_1 = sel_q;

  ym_clk_div #(
    .DIV_NORMAL(DIV_NORMAL),
    .DIV_TURBO (DIV_TURBO)
  ) u_clk_div (
    .cpu_clock(cpu_clock),
    .reset    (reset),
    .turbo    (bus.turbo),
    .ym_clock (bus.ym_clock)
  );

endmodule

// File: doc/ym_bus_sequencer.md
Name: ym_bus_sequencer

Overview:
- Z80-side I/O sequencer that sits directly downstream of the CPU bus and drives the shared BC1/BDIR pins of two YM2149 PSGs in TurboSound arrangement.
- Qualifies IORQ/WR/RD cycles on ports #FFFD (register latch / read) and #BFFD (data write).
- Tracks the TurboSound chip-select writes (#FF / #FE to #FFFD).
- Generates the PSG clock from cpu_clock with a glitch-free normal/turbo divider.

Parameters:
- QUAL_CYCLES, 1, consecutive cpu_clock samples an access must be seen before BC1/BDIR are driven (1..3).
- DIV_NORMAL, 2, cpu_clock divide ratio for ym_clock when turbo=0 (even, >=2).
- DIV_TURBO, 4, cpu_clock divide ratio for ym_clock when turbo=1 (even, >=2).

Ports:
- cpu_clock  in  1  Z80 clock; sole clock of the block.
- reset  in  1  asynchronous, active-high reset.
- iorq  in  1  Z80 IORQ, active low.
- m1  in  1  Z80 M1, active low; iorq&m1 low together = interrupt acknowledge, ignored.
- wr  in  1  Z80 WR, active low.
- rd  in  1  Z80 RD, active low.
- dos  in  1  TR-DOS active when low; all PSG decoding disabled.
- a15, a14, a1, a0  in  1 each  address bits used for port decode.
- d  in  8  Z80 data bus, used only for chip-select detection.
- turbo  in  1  1 = cpu_clock is 7 MHz, 0 = 3.5 MHz.
- bc1  out  1  PSG BC1.
- bdir  out  1  PSG BDIR.
- ym_0  out  1  chip-enable for PSG 0, active high.
- ym_1  out  1  chip-enable for PSG 1, active high.
- ym_clock  out  1  PSG clock, 1.75 MHz in both modes.

Behaviour:
Port decode (combinational):
- #FFFD = a15=1, a14=1, a1=0, a0=1.
- #BFFD = a15=1, a14=0, a1=0, a0=1.
- Valid only with dos=1, m1=1, iorq=0, and exactly one of wr/rd low.
- Access classes:
  - LATCH: #FFFD write, d != #FF and d != #FE.
  - SELECT: #FFFD write, d = #FF or #FE.
  - WRITE: #BFFD write.
  - READ: #FFFD read.
  - Any other combination, including #BFFD read, is a NONE access.

FSM states: IDLE, QUAL, DRIVE, HOLD. All state is sampled on the rising edge of cpu_clock.
- IDLE -> QUAL on any non-NONE class; the class is captured.
- QUAL counts the class as stable for QUAL_CYCLES samples, then -> DRIVE.
  - Class change or iorq high while in QUAL -> HOLD, or IDLE if iorq is high.
- DRIVE drives the captured class:
  - LATCH: bc1=1, bdir=1.
  - WRITE: bc1=0, bdir=1.
  - READ: bc1=1, bdir=0.
  - SELECT: bc1=0, bdir=0. On DRIVE entry the selected chip is updated: #FF -> chip 0, #FE -> chip 1.
  - DRIVE persists while iorq=0, then -> IDLE.
- HOLD: bc1=bdir=0 until iorq=1, then -> IDLE. Used for aborted or illegal cycles, and for wr and rd both low.

Output timing:
- bc1 and bdir are the registered DRIVE decode ANDed with ~iorq (combinational). They therefore deassert in the same delta that iorq rises; assertion latency is QUAL_CYCLES+1 clocks from the first valid sample.
- ym_0 = (sel==0), ym_1 = (sel==1), registered.

ym_clock:
- Counter toggles ym_clock every DIV/2 cycles.
- A turbo change is latched only when the counter wraps with ym_clock going low. No high or low phase is ever shorter than DIV_NORMAL/2 cycles.

Reset (asynchronous, any time including mid-access):
- FSM=IDLE, bc1=0, bdir=0, sel=0 so ym_0=1 and ym_1=0, ym_clock=0, counter=0, latched turbo=0.
- The first access after reset must still meet qualification.

Boundary cases:
- dos=0 during DRIVE: outputs held until iorq rises. Decode is gated on entry only.
- Back-to-back accesses with iorq high for only 1 cycle: IDLE is reached and the new access qualifies normally.

Decomposition:
- Package ym_bus_pkg:
  - state enum (IDLE/QUAL/DRIVE/HOLD);
  - access-class enum (NONE/LATCH/WRITE/READ/SELECT);
  - port match constants (FFFD, BFFD bit patterns);
  - chip-select codes 8'hFF / 8'hFE.
- Sub-module ym_clk_div holds the divider counter, the turbo latch and ym_clock.
- The FSM, decode and sel register stay in the top.

Test Plan:
1. Reset pulse, then idle 20 clocks -> bc1=0, bdir=0, ym_0=1, ym_1=0. ym_clock period = 2 cpu_clock cycles.
2. iorq=0 and wr=0 at #FFFD, d=#05, held 4 clocks -> bc1=1 and bdir=1 from clock 2 (QUAL_CYCLES=1). Both fall in the same step iorq returns high.
3. #BFFD write, d=#3C -> bc1=0, bdir=1. #FFFD read -> bc1=1, bdir=0. #7FFD write and #BFFD read -> bc1=bdir=0 throughout.
4. #FFFD write d=#FE -> bc1=bdir=0, then ym_0=0 and ym_1=1. Then #FFFD write d=#FF -> ym_0=1, ym_1=0. With m1=0 or dos=0 during the same cycles -> no change.
5. Set turbo=1 mid-period -> the current ym_clock period completes at divide-2, then the period becomes 4 clocks. No pulse is shorter than 1 clock.
6. Assert reset during a #FFFD write in DRIVE -> bc1=bdir=0 immediately. After release with iorq still low, no drive occurs until a fresh qualified access.
